// File: rtl/pcie_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcie_pkg
// Description : Shared defaults, query-index encodings and FSM state type for
//               the PCIE switch output-stage statistics logic.
// Revision    : 1.0
// ============================================================================
package pcie_pkg;

   localparam int DEF_NUM_FIFOS = 4;
   localparam int DEF_CNT_W     = 5;
   localparam int DEF_IDX_W     = 3;

   localparam logic [2:0] IDX_FIFO0 = 3'd0;
   localparam logic [2:0] IDX_FIFO1 = 3'd1;
   localparam logic [2:0] IDX_FIFO2 = 3'd2;
   localparam logic [2:0] IDX_FIFO3 = 3'd3;
   localparam logic [2:0] IDX_TOTAL = 3'd4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pop_counter_cell.sv
`default_nettype none
// ============================================================================
// Module      : pop_counter_cell
// Description : Single wrapping pop counter; a clear coinciding with an
//               increment leaves the counter at 1.
// Revision    : 1.0
// ============================================================================
module pop_counter_cell
   import pcie_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = clr_i ? CNT_W'(inc_i) : cnt_q + CNT_W'(inc_i);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/pop_counter.sv
`default_nettype none
// ============================================================================
// Module      : pop_counter
// Description : Per-output-FIFO successful-pop statistics with a registered
//               req/idx query port. Optional macro CLEAR_ON_READ_EN makes a
//               query clear the counter(s) it reads.
// Revision    : 1.0
// ============================================================================
module pop_counter
   import pcie_pkg::*;
#(
   parameter int NUM_FIFOS = DEF_NUM_FIFOS,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int IDX_W     = DEF_IDX_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_FIFOS-1:0] pop,
   input  logic [NUM_FIFOS-1:0] fifo_empty,
   input  logic                 req,
   input  logic [IDX_W-1:0]     idx,
   output logic [CNT_W-1:0]     data_out,
   output logic                 valid
);

   logic [NUM_FIFOS-1:0] inc;
   logic [NUM_FIFOS-1:0] clr;
   logic [CNT_W-1:0]     cnt_q [NUM_FIFOS];
   logic [CNT_W-1:0]     total;
   logic [CNT_W-1:0]     sel;
   logic [CNT_W-1:0]     data_q;
   state_t               state_q;
   state_t               state_d;

   // Popping an empty FIFO is an underflow attempt and never counts.
   assign inc = pop & ~fifo_empty;

   generate
      for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_cell
`ifdef CLEAR_ON_READ_EN
         assign clr[i] = req & ((idx == IDX_W'(i)) | (idx == IDX_W'(IDX_TOTAL)));
`else
         assign clr[i] = 1'b0;
`endif
         pop_counter_cell #(
            .CNT_W (CNT_W)
         ) u_cell (
            .clk   (clk),
            .reset (reset),
            .inc_i (inc[i]),
            .clr_i (clr[i]),
            .cnt_o (cnt_q[i])
         );
      end
   endgenerate

   always_comb begin
      total = '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         total = total + cnt_q[i];
      end
   end

   always_comb begin
      sel = '0;
      if (idx == IDX_W'(IDX_TOTAL)) begin
         sel = total;
      end else begin
         for (int i = 0; i < NUM_FIFOS; i++) begin
            if (idx == IDX_W'(i)) begin
               sel = cnt_q[i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else if (req) begin
         data_q <= sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req)  state_d = RESP;
         RESP:    if (!req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid = (state_q == RESP);
   end

   assign data_out = data_q;

endmodule
`default_nettype wire

// File: tb/tb_pop_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pop_counter
// Description : Self-checking bench for pop_counter against an arithmetic
//               reference model of counts, totals and query responses.
// Revision    : 1.0
// ============================================================================
module tb_pop_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] pop = '0;
   logic [3:0] fifo_empty = '0;
   logic       req = 1'b0;
   logic [2:0] idx = '0;
   logic [4:0] data_out;
   logic       valid;

   int ncomp = 0;
   int nfail = 0;

   int m_cnt [4];
   int m_data = 0;
   int m_valid = 0;

   pop_counter dut (
      .clk        (clk),
      .reset      (reset),
      .pop        (pop),
      .fifo_empty (fifo_empty),
      .req        (req),
      .idx        (idx),
      .data_out   (data_out),
      .valid      (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      ncomp++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag);
      check({tag, "_valid"}, int'(valid), m_valid);
      check({tag, "_data"}, int'(data_out), m_data);
   endtask

   // Model one posedge from the counting and query rules.
   task automatic model_edge(input logic [3:0] p, input logic [3:0] e,
                             input logic r, input int ix);
      int sum;
      sum = 0;
      for (int i = 0; i < 4; i++) sum += m_cnt[i];
      if (r) begin
         m_valid = 1;
         if (ix < 4)       m_data = m_cnt[ix];
         else if (ix == 4) m_data = sum % 32;
         else              m_data = 0;
      end else begin
         m_valid = 0;
      end
      for (int i = 0; i < 4; i++) begin
`ifdef CLEAR_ON_READ_EN
         if (r && (ix == i || ix == 4)) m_cnt[i] = 0;
`endif
         if (p[i] && !e[i]) m_cnt[i] = (m_cnt[i] + 1) % 32;
      end
   endtask

   // Entered and left at posedge+1.
   task automatic step(input logic [3:0] p, input logic [3:0] e,
                       input logic r, input int ix, input string tag);
      pop = p; fifo_empty = e; req = r; idx = 3'(ix);
      @(posedge clk);
      model_edge(p, e, r, ix);
      #1;
      check_out(tag);
   endtask

   task automatic pops(input logic [3:0] p, input int n);
      for (int k = 0; k < n; k++) step(p, 4'b0000, 1'b0, 0, "pop");
   endtask

   // Reset asserted mid-cycle: outputs must clear with no clock edge.
   task automatic do_reset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_data = 0; m_valid = 0;
      check_out({tag, "_async"});
      pop = '0; fifo_empty = '0; req = 1'b0; idx = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_out({tag, "_post"});
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;

      #1;
      check_out("init_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_out("idle");

      // Counting and query across all indices
      pops(4'b1111, 3);
      for (int k = 0; k <= 4; k++) step(4'b0000, 4'b0000, 1'b1, k, "q_all");
      step(4'b0000, 4'b0000, 1'b0, 0, "q_hold");

      // Reset with nonzero counters and a live response
      pops(4'b0101, 2);
      step(4'b0000, 4'b0000, 1'b1, 0, "pre_rst");
      do_reset("rst");
      for (int k = 0; k <= 4; k++) step(4'b0000, 4'b0000, 1'b1, k, "after_rst");

      // Reset released while req is already high
      pop = '0; fifo_empty = '0; req = 1'b1; idx = 3'd4;
      #2; reset = 1'b1; #1; reset = 1'b0;
      m_valid = 0; m_data = 0;
      #1;
      check_out("rel_mid_query");
      @(posedge clk);
      model_edge(4'b0000, 4'b0000, 1'b1, 4);
      #1;
      check_out("rel_first_resp");
      step(4'b0000, 4'b0000, 1'b0, 0, "rel_idle");

      // Empty filter
      do_reset("rst_empty");
      step(4'b0100, 4'b0100, 1'b0, 0, "empty_pop");
      step(4'b0100, 4'b0100, 1'b0, 0, "empty_pop");
      pops(4'b0100, 2);
      step(4'b0000, 4'b0000, 1'b1, 2, "empty_q2");
      step(4'b0000, 4'b0000, 1'b1, 5, "inval_q5");
      step(4'b0000, 4'b0000, 1'b1, 7, "inval_q7");

      // Wrap on FIFO 0 and truncated total
      do_reset("rst_wrap");
      pops(4'b0001, 33);
      step(4'b0000, 4'b0000, 1'b1, 0, "wrap_q0");
      do_reset("rst_tot");
      pops(4'b0110, 20);
      step(4'b0000, 4'b0000, 1'b1, 4, "wrap_total");

      // Same-cycle pop and query
      do_reset("rst_same");
      pops(4'b0010, 5);
      step(4'b0010, 4'b0000, 1'b1, 1, "same_q1");
      step(4'b0000, 4'b0000, 1'b1, 1, "same_q1_again");

      // Clear-on-read sequence (queries are read-only without the macro)
      do_reset("rst_cor");
      pops(4'b1000, 7);
      step(4'b0000, 4'b0000, 1'b1, 3, "cor_q3_a");
      step(4'b0000, 4'b0000, 1'b1, 3, "cor_q3_b");
      step(4'b1000, 4'b0000, 1'b1, 3, "cor_q3_pop");
      step(4'b0000, 4'b0000, 1'b1, 3, "cor_q3_c");
      step(4'b0000, 4'b0000, 1'b0, 0, "cor_idle");

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         step(4'($urandom), 4'($urandom & $urandom), 1'($urandom),
              int'($urandom_range(0, 7)), "rand");
      end
      for (int k = 0; k <= 5; k++) step(4'b0000, 4'b0000, 1'b1, k, "rand_final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
